// File: rtl/encoder_ctrl.sv
// Rotary-encoder MMIO slot: bounded shaft position with wrap/saturate,
// rotation acceleration, sticky change flag, event counter and irq.
module encoder_ctrl #(
  parameter int PW           = 8,
  parameter int ACCEL_WINDOW = 2_000_000,
  parameter int ACCEL_RUN    = 4,
  parameter int ACCEL_STEP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        step_cw,
  input  logic        step_ccw,
  output logic        irq
);

  localparam int WW = $clog2(ACCEL_WINDOW + 1);
  localparam int RW = $clog2(ACCEL_RUN + 1);
  localparam logic [WW-1:0] WIN_LD  = WW'(ACCEL_WINDOW);
  localparam logic [RW-1:0] RUN_TOP = RW'(ACCEL_RUN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [PW:0]   FSTEP   = (PW+1)'(ACCEL_STEP);
  localparam logic [PW:0]   ONE     = (PW+1)'(1);

  typedef enum logic {SLOW, FAST} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pos, max_r;
  logic [3:0]    ctrl;
  logic          changed, last_dir;
  logic [7:0]    evcnt;
  logic [WW-1:0] win;
  logic [RW-1:0] run, run_nx;

  logic en, wrap, irq_en, accel_en;
  logic wr, wr_pos, wr_max, wr_ctrl, wr_stat;
  logic step, dir, in_run, fast, fast_exit;
  logic [PW:0]   pos_ext, mx, mx1, sum, d, dfast, nxt;
  logic [PW-1:0] pos_step, pos_wr, max_wr, pos_base;

  assign en       = ctrl[0];
  assign wrap     = ctrl[1];
  assign irq_en   = ctrl[2];
  assign accel_en = ctrl[3];

  assign wr      = cs & write;
  assign wr_pos  = wr & (addr[1:0] == 2'd0);
  assign wr_max  = wr & (addr[1:0] == 2'd1);
  assign wr_ctrl = wr & (addr[1:0] == 2'd2);
  assign wr_stat = wr & (addr[1:0] == 2'd3);

  // A POS write in the same cycle swallows the step completely
  assign step   = en & (step_cw ^ step_ccw) & ~wr_pos;
  assign dir    = step_ccw;
  assign in_run = (dir == last_dir) && (win != '0);

  assign fast_exit = (state == FAST) &&
                     (!en || !accel_en || win == '0 ||
                      (step && dir != last_dir));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOW;
      run   <= '0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run;
    unique case (state)
      SLOW: begin
        if (step) begin
          if (!in_run)
            run_nx = RUN_ONE;
          else if (run != RUN_TOP)
            run_nx = run + RUN_ONE;
          if (run_nx >= RUN_TOP && accel_en)
            state_nx = FAST;
        end
      end
      FAST: begin
        if (fast_exit) begin
          state_nx = SLOW;
          run_nx   = '0;
        end
      end
      default: state_nx = SLOW;
    endcase
  end

  always_comb begin
    fast  = (state == FAST);
    dfast = (FSTEP > mx) ? mx : FSTEP;
    d     = (fast && !fast_exit) ? dfast : ONE;
  end

  always_comb begin
    pos_ext = {1'b0, pos};
    mx      = {1'b0, max_r};
    mx1     = mx + ONE;
    sum     = pos_ext + d;
    nxt     = pos_ext;
    if (!dir) begin
      if (sum > mx) nxt = wrap ? sum - mx1 : mx;
      else          nxt = sum;
    end else begin
      if (pos_ext < d) nxt = wrap ? pos_ext + mx1 - d : '0;
      else             nxt = pos_ext - d;
    end
  end

  assign pos_step = nxt[PW-1:0];
  assign pos_wr   = (wr_data[PW-1:0] > max_r) ? max_r : wr_data[PW-1:0];
  assign max_wr   = (wr_data[PW-1:0] == '0) ? PW'(1) : wr_data[PW-1:0];
  assign pos_base = wr_pos ? pos_wr : (step ? pos_step : pos);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos      <= '0;
      max_r    <= PW'(19);
      ctrl     <= 4'b0011;
      changed  <= 1'b0;
      last_dir <= 1'b0;
      evcnt    <= '0;
      win      <= '0;
    end else begin
      if (wr_max && pos_base > max_wr) pos <= max_wr;
      else                             pos <= pos_base;
      if (wr_max)  max_r <= max_wr;
      if (wr_ctrl) ctrl  <= wr_data[3:0];
      if (wr_stat && wr_data[0]) changed <= 1'b0;
      if (wr_stat && wr_data[8]) evcnt   <= '0;
      if (step) begin
        changed  <= 1'b1;
        last_dir <= dir;
        if (evcnt != 8'hff) evcnt <= evcnt + 8'd1;
      end
      if (step)             win <= WIN_LD;
      else if (win != '0)   win <= win - WW'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr[1:0])
      2'd0: rd_data[PW-1:0] = pos;
      2'd1: rd_data[PW-1:0] = max_r;
      2'd2: rd_data[3:0]    = ctrl;
      2'd3: rd_data[15:0]   = {evcnt, 5'b0, fast, last_dir, changed};
      default: rd_data = '0;
    endcase
  end

  assign irq = changed & irq_en;

  logic unused_ok;
  assign unused_ok = &{1'b0, read, addr[4:2], wr_data, nxt[PW]};

endmodule
